alu_shift_sequencer: RTL and testbench

- Multi-cycle controller that drives the ALU's arithmetic left shifter datapath one bit per cycle.
- Accepts an operand and a shift amount over a valid/ready handshake and iterates a shift-by-1 step until the count is exhausted or the value becomes zero.
- Presents the result with carry-out and overflow flags over a second valid/ready handshake.
- Sits between the ALU operation decoder and the result mux, so one small shifter serves any shift amount.

---
 rtl/alu_shift_sequencer.sv | 105 ++++++++++
 tb/tb_alu_shift_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle arithmetic left shifter: accepts (a, shift), shifts one bit per
// cycle until the clamped count runs out or the value hits zero, then returns y/carry/ovf.
module alu_shift_sequencer #(
  parameter int WIDTH   = 4,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               carry,
  output logic               ovf,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_init;
  logic             accept;
  logic             step;

  // Shift amounts of WIDTH or more all yield zero, so the count saturates at WIDTH.
  always_comb begin
    if (32'(shift) >= 32'(WIDTH)) cnt_init = CNT_W'(WIDTH);
    else                          cnt_init = CNT_W'(shift);
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; the sender holds its payload until then. in_ready is high only in IDLE,
  // out_valid only in DONE, so a result handoff and a new accept never coincide.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (cnt_init == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (acc == '0) begin
          state_nxt = DONE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc   <= a;
        cnt   <= cnt_init;
        carry <= 1'b0;
        ovf   <= 1'b0;
      end else if (step) begin
        // One arithmetic-shift-left-by-1 step with zero fill into the LSB.
        acc   <= {acc[WIDTH-2:0], 1'b0};
        carry <= carry | acc[WIDTH-1];
        ovf   <= ovf | (acc[WIDTH-1] ^ acc[WIDTH-2]);
        cnt   <= cnt - CNT_W'(1);
      end
    end
  end

  assign y = acc;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer: hand-computed vectors, latency,
// backpressure, clamping, early termination and mid-shift reset.
module tb_alu_shift_sequencer;

  localparam int WIDTH   = 4;
  localparam int SHIFT_W = 4;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [SHIFT_W-1:0] shift;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic               carry;
  logic               ovf;
  logic               busy;

  int n_checks;
  int n_errors;

  // Expected {ovf, carry, y} per command, in issue order.
  logic [WIDTH+1:0] exp_q[$];

  alu_shift_sequencer #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one accept edge, then scramble the inputs.
  task automatic send(input logic [WIDTH-1:0] av, input logic [SHIFT_W-1:0] sv,
                      input logic [WIDTH+1:0] exp_res);
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    a        = av;
    shift    = sv;
    exp_q.push_back(exp_res);
    tick();
    in_valid = 1'b0;
    a        = WIDTH'($urandom_range(0, 15));
    shift    = SHIFT_W'($urandom_range(0, 15));
  endtask

  // Called right after the accept edge: count edges until out_valid, then
  // compare the result against the scoreboard.
  task automatic wait_done(input string tag, input int exp_edges);
    int edges;
    logic [WIDTH+1:0] exp_res;
    edges = 0;
    while (!out_valid && edges < 20) begin
      check({tag, "_busy_shift"}, {busy, in_ready}, 2'b10);
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, exp_edges);
    exp_res = exp_q.pop_front();
    check({tag, "_y"},     y,     exp_res[WIDTH-1:0]);
    check({tag, "_carry"}, carry, exp_res[WIDTH]);
    check({tag, "_ovf"},   ovf,   exp_res[WIDTH+1]);
    check({tag, "_busy_done"}, busy, 1'b1);
  endtask

  // Complete the output handshake and confirm the return to IDLE with result retained.
  task automatic finish_cmd(input string tag);
    logic [WIDTH+1:0] held;
    held = {ovf, carry, y};
    out_ready = 1'b1;
    tick();
    check({tag, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
    check({tag, "_retain"}, {ovf, carry, y}, held);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    shift     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("reset_ctrl", {in_ready, out_valid, busy}, 3'b100);
    check("reset_data", {ovf, carry, y}, 6'b000000);
    reset = 1'b0;

    // 0101 << 1 = 1010, sign flips
    send(4'b0101, 4'd1, {1'b1, 1'b0, 4'b1010});
    wait_done("t1", 1);
    finish_cmd("t1");

    // 1111 << 2 = 1100, ones shifted out, sign never changes
    send(4'b1111, 4'd2, {1'b0, 1'b1, 4'b1100});
    wait_done("t2", 2);
    finish_cmd("t2");

    // zero shift passes straight to DONE
    send(4'b0011, 4'd0, {1'b0, 1'b0, 4'b0011});
    wait_done("t3", 0);
    finish_cmd("t3");

    // shift 9 clamps to 4
    send(4'b1001, 4'd9, {1'b1, 1'b1, 4'b0000});
    wait_done("t4", 4);
    finish_cmd("t4");

    // early termination: zero after first step, DONE one edge later
    send(4'b1000, 4'd3, {1'b1, 1'b1, 4'b0000});
    wait_done("t5", 2);
    finish_cmd("t5");

    // zero operand with nonzero count
    send(4'b0000, 4'd2, {1'b0, 1'b0, 4'b0000});
    wait_done("t6", 1);
    finish_cmd("t6");

    // backpressure with a second command held while busy
    out_ready = 1'b0;
    send(4'b0110, 4'd1, {1'b1, 1'b0, 4'b1100});
    wait_done("bp", 1);
    in_valid = 1'b1;
    a        = 4'b0011;
    shift    = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_ctrl", {out_valid, in_ready}, 2'b10);
      check("bp_hold_data", {ovf, carry, y}, {1'b1, 1'b0, 4'b1100});
    end
    out_ready = 1'b1;
    tick();
    check("bp_handoff", {in_ready, out_valid}, 2'b10);
    check("bp_handoff_y", y, 4'b1100);
    exp_q.push_back({1'b0, 1'b0, 4'b0011});
    tick();
    in_valid = 1'b0;
    wait_done("bp2", 0);
    finish_cmd("bp2");

    // reset in the middle of a shift
    send(4'b0001, 4'd3, {1'b0, 1'b0, 4'b1000});
    void'(exp_q.pop_back());
    tick();
    check("rst_mid_y", y, 4'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_ctrl", {in_ready, out_valid, busy}, 3'b100);
    check("rst_mid_data", {ovf, carry, y}, 6'b000000);

    // normal operation after reset
    send(4'b0011, 4'd1, {1'b0, 1'b0, 4'b0110});
    wait_done("post", 1);
    finish_cmd("post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
